// File: rtl/spi_ram_burst.sv
// SPI-side RAM with independent read/write pointers, optional burst auto-increment,
// address-range checking and a sticky command-error flag.
module spi_ram_burst #(
    parameter int MEM_WIDTH = 8,
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int AUTO_INC  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_valid,
    input  logic [MEM_WIDTH+1:0] din,
    output logic [MEM_WIDTH-1:0] dout,
    output logic                 tx_valid,
    output logic                 cmd_err
);

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_t;

    localparam logic [ADDR_SIZE-1:0] LAST    = ADDR_SIZE'(MEM_DEPTH - 1);
    localparam logic [ADDR_SIZE:0]   DEPTH_W = (ADDR_SIZE + 1)'(MEM_DEPTH);

    logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic                 wr_armed;
    logic                 rd_armed;

    cmd_t                 cmd;
    logic [ADDR_SIZE-1:0] addr;
    logic [MEM_WIDTH-1:0] payload;
    logic                 addr_ok;
    logic [ADDR_SIZE-1:0] wr_next;
    logic [ADDR_SIZE-1:0] rd_next;
    logic                 wr_fire;

    always_comb begin
        cmd     = cmd_t'(din[MEM_WIDTH+1:MEM_WIDTH]);
        payload = din[MEM_WIDTH-1:0];
        addr    = din[ADDR_SIZE-1:0];
        // One extra bit so a full 2**ADDR_SIZE depth still compares correctly.
        addr_ok = ({1'b0, addr} < DEPTH_W);
        wr_next = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        rd_next = (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
        wr_fire = rx_valid && (cmd == WR_DATA) && wr_armed;
    end

    // Contents are deliberately not reset so the array maps onto RAM.
    always_ff @(posedge clk) begin
        if (!rst && wr_fire) begin
            mem[wr_ptr] <= payload;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout     <= '0;
            tx_valid <= 1'b0;
            cmd_err  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wr_armed <= 1'b0;
            rd_armed <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            if (rx_valid) begin
                case (cmd)
                    WR_ADDR: begin
                        if (addr_ok) begin
                            wr_ptr   <= addr;
                            wr_armed <= 1'b1;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                    WR_DATA: begin
                        if (wr_armed) begin
                            if (AUTO_INC != 0) wr_ptr <= wr_next;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                    RD_ADDR: begin
                        if (addr_ok) begin
                            rd_ptr   <= addr;
                            rd_armed <= 1'b1;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                    RD_DATA: begin
                        if (rd_armed) begin
                            dout     <= mem[rd_ptr];
                            tx_valid <= 1'b1;
                            if (AUTO_INC != 0) rd_ptr <= rd_next;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Self-checking bench: three parameterisations driven in lockstep against a behavioural model.
module tb_spi_ram_burst;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_valid = 1'b0;
    logic [9:0] din = '0;

    logic [7:0] dout_w [3];
    logic       txv_w  [3];
    logic       err_w  [3];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    spi_ram_burst #(.MEM_WIDTH(8), .MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) dut_full (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .din(din),
        .dout(dout_w[0]), .tx_valid(txv_w[0]), .cmd_err(err_w[0]));

    spi_ram_burst #(.MEM_WIDTH(8), .MEM_DEPTH(200), .ADDR_SIZE(8), .AUTO_INC(1)) dut_d200 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .din(din),
        .dout(dout_w[1]), .tx_valid(txv_w[1]), .cmd_err(err_w[1]));

    spi_ram_burst #(.MEM_WIDTH(8), .MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) dut_noinc (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .din(din),
        .dout(dout_w[2]), .tx_valid(txv_w[2]), .cmd_err(err_w[2]));

    // Reference model state, one slot per instance.
    int m_depth [3] = '{256, 200, 256};
    bit m_inc   [3] = '{1'b1, 1'b1, 1'b0};
    int m_mem   [3][256];
    bit m_known [3][256];
    int m_wp [3], m_rp [3], m_dout [3];
    bit m_wa [3], m_ra [3], m_err [3], m_txv [3], m_dk [3];

    task automatic model_step(input int k, input bit r, input bit rv, input logic [9:0] d);
        int a;
        if (r) begin
            m_dout[k] = 0; m_dk[k] = 1'b1; m_txv[k] = 1'b0; m_err[k] = 1'b0;
            m_wp[k] = 0; m_rp[k] = 0; m_wa[k] = 1'b0; m_ra[k] = 1'b0;
            return;
        end
        m_txv[k] = 1'b0;
        if (!rv) return;
        a = int'(d[7:0]);
        case (d[9:8])
            2'd0: if (a < m_depth[k]) begin m_wp[k] = a; m_wa[k] = 1'b1; end else m_err[k] = 1'b1;
            2'd1: if (m_wa[k]) begin
                      m_mem[k][m_wp[k]] = a;
                      m_known[k][m_wp[k]] = 1'b1;
                      if (m_inc[k]) m_wp[k] = (m_wp[k] + 1) % m_depth[k];
                  end else m_err[k] = 1'b1;
            2'd2: if (a < m_depth[k]) begin m_rp[k] = a; m_ra[k] = 1'b1; end else m_err[k] = 1'b1;
            2'd3: if (m_ra[k]) begin
                      m_dout[k] = m_mem[k][m_rp[k]];
                      m_dk[k]   = m_known[k][m_rp[k]];
                      m_txv[k]  = 1'b1;
                      if (m_inc[k]) m_rp[k] = (m_rp[k] + 1) % m_depth[k];
                  end else m_err[k] = 1'b1;
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("model_txv[%0d]", k), 32'(txv_w[k]), 32'(m_txv[k]));
            chk($sformatf("model_err[%0d]", k), 32'(err_w[k]), 32'(m_err[k]));
            if (m_dk[k]) chk($sformatf("model_dout[%0d]", k), 32'(dout_w[k]), 32'(m_dout[k]));
        end
    endtask

    task automatic step(input bit r, input bit rv, input logic [9:0] d);
        rst = r; rx_valid = rv; din = d;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, r, rv, d);
        #1;
        check_all();
    endtask

    task automatic cmd(input logic [1:0] c, input logic [7:0] p);
        step(1'b0, 1'b1, {c, p});
    endtask

    typedef struct {
        bit       r;
        bit       rv;
        bit [1:0] c;
        bit [7:0] pay;
        bit       txv;
        bit [7:0] dout;
        bit       err;
    } vec_t;

    vec_t vt [$];

    initial begin
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 256; i++) m_known[k][i] = 1'b0;

        // Burst write then burst read on the default instance.
        vt.push_back('{1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0});
        vt.push_back('{1'b0, 1'b1, 2'd0, 8'h05, 1'b0, 8'h00, 1'b0});
        vt.push_back('{1'b0, 1'b1, 2'd1, 8'hA5, 1'b0, 8'h00, 1'b0});
        vt.push_back('{1'b0, 1'b1, 2'd1, 8'h5A, 1'b0, 8'h00, 1'b0});
        vt.push_back('{1'b0, 1'b1, 2'd1, 8'h3C, 1'b0, 8'h00, 1'b0});
        vt.push_back('{1'b0, 1'b1, 2'd2, 8'h05, 1'b0, 8'h00, 1'b0});
        vt.push_back('{1'b0, 1'b1, 2'd3, 8'h00, 1'b1, 8'hA5, 1'b0});
        vt.push_back('{1'b0, 1'b1, 2'd3, 8'h00, 1'b1, 8'h5A, 1'b0});
        vt.push_back('{1'b0, 1'b1, 2'd3, 8'h00, 1'b1, 8'h3C, 1'b0});
        vt.push_back('{1'b0, 1'b0, 2'd3, 8'h00, 1'b0, 8'h3C, 1'b0});
        foreach (vt[i]) begin
            step(vt[i].r, vt[i].rv, {vt[i].c, vt[i].pay});
            chk($sformatf("vec%0d_txv", i), 32'(txv_w[0]), 32'(vt[i].txv));
            chk($sformatf("vec%0d_dout", i), 32'(dout_w[0]), 32'(vt[i].dout));
            chk($sformatf("vec%0d_err", i), 32'(err_w[0]), 32'(vt[i].err));
        end

        // Wrap at MEM_DEPTH-1 and out-of-range write address on the 200-deep instance.
        cmd(2'd0, 8'd199);
        cmd(2'd1, 8'h11);
        cmd(2'd1, 8'h22);
        cmd(2'd0, 8'd200);
        chk("d200_range_err", 32'(err_w[1]), 32'd1);
        chk("full_range_ok", 32'(err_w[0]), 32'd0);
        cmd(2'd1, 8'h33);
        cmd(2'd2, 8'd199);
        cmd(2'd3, 8'h00);
        chk("d200_rd199", 32'(dout_w[1]), 32'h11);
        cmd(2'd3, 8'h00);
        chk("d200_rd0_wrap", 32'(dout_w[1]), 32'h22);
        cmd(2'd3, 8'h00);
        chk("d200_rd1_ptr_held", 32'(dout_w[1]), 32'h33);

        // Unarmed data commands straight after reset.
        step(1'b1, 1'b0, '0);
        chk("rst_err_clear", 32'(err_w[1]), 32'd0);
        cmd(2'd1, 8'h77);
        chk("unarmed_wr_err", 32'(err_w[0]), 32'd1);
        cmd(2'd3, 8'h00);
        chk("unarmed_rd_txv", 32'(txv_w[0]), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 10'(i));
        chk("err_sticky", 32'(err_w[0]), 32'd1);
        cmd(2'd2, 8'd0);
        cmd(2'd3, 8'h00);
        chk("d200_mem0_untouched", 32'(dout_w[1]), 32'h22);
        step(1'b1, 1'b0, '0);
        chk("err_cleared_by_rst", 32'(err_w[0]), 32'd0);

        // Pointer hold without auto-increment.
        cmd(2'd0, 8'h10);
        cmd(2'd1, 8'h9C);
        cmd(2'd2, 8'h10);
        for (int i = 0; i < 3; i++) begin
            cmd(2'd3, 8'h00);
            chk($sformatf("noinc_rd%0d_dout", i), 32'(dout_w[2]), 32'h9C);
            chk($sformatf("noinc_rd%0d_txv", i), 32'(txv_w[2]), 32'd1);
        end

        // Reset coinciding with a read drops the pulse and disarms.
        cmd(2'd3, 8'h00);
        chk("pre_rst_txv", 32'(txv_w[2]), 32'd1);
        step(1'b1, 1'b1, {2'd3, 8'h00});
        chk("rst_rd_txv", 32'(txv_w[0]), 32'd0);
        chk("rst_rd_dout", 32'(dout_w[2]), 32'd0);
        cmd(2'd3, 8'h00);
        chk("rst_disarm_txv", 32'(txv_w[0]), 32'd0);
        chk("rst_disarm_err", 32'(err_w[0]), 32'd1);

        // Idle bus with toggling din must change nothing.
        step(1'b1, 1'b0, '0);
        cmd(2'd0, 8'h40);
        cmd(2'd1, 8'hE1);
        cmd(2'd2, 8'h40);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 10'($urandom));
        chk("idle_err", 32'(err_w[0]), 32'd0);
        cmd(2'd3, 8'h00);
        chk("idle_mem_kept", 32'(dout_w[0]), 32'hE1);
        cmd(2'd1, 8'h5F);
        cmd(2'd3, 8'h00);
        chk("idle_ptrs_kept", 32'(dout_w[0]), 32'h5F);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bit r;
            bit v;
            r = ($urandom_range(0, 79) == 0);
            v = ($urandom_range(0, 9) < 7);
            step(r, v, 10'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_ram_burst.md
Name: spi_ram_burst

Overview:
Parametrised single-port RAM that sits behind the SPI slave. It decodes the same 2-bit-command + payload word (`din`) as the current SPI RAM. On top of that it adds:
- independent read and write address pointers;
- optional auto-increment, for burst access without resending the address;
- an address-range check;
- a sticky command-error flag.

It sits between the SPI slave's rx path (`rx_valid`, `din`) and its tx path (`tx_valid`, `dout`).

Parameters:
- MEM_WIDTH, 8, data word width in bits; `din` is MEM_WIDTH+2 bits wide.
- MEM_DEPTH, 256, number of words; need not be a power of two.
- ADDR_SIZE, 8, pointer width. Legal when ADDR_SIZE <= MEM_WIDTH and 2**ADDR_SIZE >= MEM_DEPTH.
- AUTO_INC, 1, 1 = pointer post-increments after each data access; 0 = pointer holds.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_valid  input  1  `din` valid this cycle; one command per asserted cycle.
- din  input  MEM_WIDTH+2  [MEM_WIDTH+1:MEM_WIDTH] = cmd; [MEM_WIDTH-1:0] = payload.
- dout  output  MEM_WIDTH  read data.
- tx_valid  output  1  one-cycle pulse, `dout` valid.
- cmd_err  output  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset (rst=1 at clk edge): dout=0, tx_valid=0, cmd_err=0, wr_ptr=0, rd_ptr=0, wr_armed=0, rd_armed=0.
  - Memory contents are not reset.
  - rst has priority over rx_valid in the same cycle.
  - A read pulse pending from the previous cycle is dropped: tx_valid=0 in the cycle after reset.
- rx_valid=0: no state change; tx_valid=0 next cycle.
- Commands, acted on only when rx_valid=1; addr = din[ADDR_SIZE-1:0], upper payload bits ignored:
  - cmd 00 (WR_ADDR): if addr < MEM_DEPTH, then wr_ptr<=addr and wr_armed<=1. Otherwise cmd_err<=1 and wr_ptr/wr_armed are unchanged.
  - cmd 01 (WR_DATA): if wr_armed, then mem[wr_ptr]<=din[MEM_WIDTH-1:0], and if AUTO_INC, wr_ptr advances per the wrap rule below. If not armed, the write is dropped and cmd_err<=1.
  - cmd 10 (RD_ADDR): if addr < MEM_DEPTH, then rd_ptr<=addr and rd_armed<=1. Otherwise cmd_err<=1.
  - cmd 11 (RD_DATA): if rd_armed:
    - dout<=mem[rd_ptr] and tx_valid<=1 on the same edge, so both are visible the cycle after the command (latency 1);
    - if AUTO_INC, rd_ptr advances per the wrap rule below.
    If not armed: cmd_err<=1, tx_valid stays 0, dout holds.
- Wrap rule: pointer == MEM_DEPTH-1 -> next value 0; otherwise +1. The arithmetic is ADDR_SIZE bits wide.
- tx_valid is high for exactly one cycle per accepted RD_DATA. Back-to-back RD_DATA commands give back-to-back pulses.
- dout holds its last read value between reads.
- Single-port memory: at most one access per cycle. A read returns the value from before any write in the same edge; this cannot occur by protocol.
- Read-after-write to the same address on consecutive commands returns the new data.
- Write pointer and read pointer are independent. Arming persists until rst.

Test Plan:
1. Reset, then WR_ADDR 0x05, then WR_DATA 0xA5, 0x5A, 0x3C (AUTO_INC=1). Then RD_ADDR 0x05 and three RD_DATA commands -> dout = 0xA5, 0x5A, 0x3C. Each value is accompanied by a 1-cycle tx_valid, arriving 1 cycle after its command. cmd_err=0 throughout.
2. MEM_DEPTH=200: WR_ADDR 199, WR_DATA 0x11, WR_DATA 0x22 -> mem[199]=0x11 and mem[0]=0x22 (wrap). Then WR_ADDR 200 -> cmd_err=1 and wr_ptr stays 1.
3. Directly after reset: WR_DATA 0x77 and RD_DATA -> no memory write, tx_valid stays 0, cmd_err=1. cmd_err stays 1 until rst. After rst, cmd_err=0.
4. AUTO_INC=0: RD_ADDR 0x10, then RD_DATA x3 with mem[0x10]=0x9C -> dout=0x9C three times, with three tx_valid pulses.
5. Assert rst in the same cycle as an RD_DATA (rx_valid=1) -> tx_valid=0 and dout=0 the next cycle, and rd_armed cleared.
6. With rx_valid=0 and `din` toggling random values for 20 cycles -> no change to memory, pointers, cmd_err or tx_valid.
